// File: rtl/spike_mac.sv
// Spike-gated multiply-accumulate for one spiking neuron: 25 spike-gated 16-bit
// weights are summed by a balanced adder tree into a wrapping 20-bit membrane sum.
module spike_mac (
  output logic [19:0]  sum,
  input  logic         clk,
  input  logic [24:0]  p,
  input  logic [399:0] w,
  input  logic         rst_n
);

  logic [20:0] w_l0 [0:24];
  logic [20:0] w_l1 [0:12];
  logic [20:0] w_l2 [0:6];
  logic [20:0] w_l3 [0:3];
  logic [20:0] w_l4 [0:1];
  logic [20:0] w_lane_sum;
  logic [19:0] r_acc;

  // The odd element left over at each tree level is passed up unchanged.
  always_comb begin
    for (int unsigned i = 0; i < 25; i++) begin
      w_l0[i] = p[i] ? {5'd0, w[16*i +: 16]} : '0;
    end
    for (int unsigned i = 0; i < 12; i++) begin
      w_l1[i] = w_l0[2*i] + w_l0[2*i+1];
    end
    w_l1[12] = w_l0[24];
    for (int unsigned i = 0; i < 6; i++) begin
      w_l2[i] = w_l1[2*i] + w_l1[2*i+1];
    end
    w_l2[6] = w_l1[12];
    for (int unsigned i = 0; i < 3; i++) begin
      w_l3[i] = w_l2[2*i] + w_l2[2*i+1];
    end
    w_l3[3] = w_l2[6];
    for (int unsigned i = 0; i < 2; i++) begin
      w_l4[i] = w_l3[2*i] + w_l3[2*i+1];
    end
    w_lane_sum = w_l4[0] + w_l4[1];
  end

  // Modulo-2^20 wrap comes from truncating the 21-bit addition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= 20'(r_acc + w_lane_sum);
    end
  end

  assign sum = r_acc;

endmodule

// File: tb/tb_spike_mac.sv
// Directed-vector bench for spike_mac: reset, serial and parallel dot products,
// lane gating, wrap-around and mid-run reset, all against hand-computed values.
module tb_spike_mac;

  logic         clk;
  logic         rst_n;
  logic [24:0]  p;
  logic [399:0] w;
  logic [19:0]  sum;

  int unsigned n_vec;
  int unsigned n_err;

  spike_mac u_dut (
    .sum   (sum),
    .clk   (clk),
    .p     (p),
    .w     (w),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: sum=0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    p     = '0;
    w     = '0;
    step();
    check(tag, sum, 20'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int unsigned ser_w   [25] = '{1,1,5,1,8,6,5,2,5,1,3,1,2,3,7,5,4,2,4,6,7,8,4,3,2};
  bit          ser_p   [25] = '{1,1,1,1,0,0,0,1,0,1,1,0,1,0,0,1,0,1,1,1,0,1,0,1,1};
  int unsigned ser_run [25] = '{1,2,7,8,8,8,8,10,10,11,14,14,16,16,16,21,21,23,27,33,33,41,41,44,46};

  logic [399:0] w_tmp;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    p     = '0;
    w     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("por", sum, 20'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load a nonzero value so the asynchronous clear is observable.
    @(negedge clk);
    p = 25'h1;
    w = 400'h5;
    step();
    check("preload", sum, 20'd5);

    @(negedge clk);
    p = '1;
    w = '1;
    #2 rst_n = 1'b0;
    #1 check("rst_async", sum, 20'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold", sum, 20'd0);
    end
    @(negedge clk);
    p     = '0;
    w     = '0;
    rst_n = 1'b1;

    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      p = {24'd0, ser_p[k]};
      w = {384'd0, 16'(ser_w[k])};
      step();
      check($sformatf("serial%0d", k + 1), sum, 20'(ser_run[k]));
    end

    // Half-cycle reset pulse while the next lane-0 input is already presented.
    #1 rst_n = 1'b0;
    #1 check("midrst_async", sum, 20'd0);
    @(negedge clk);
    p = 25'h1;
    w = 400'd9;
    #2 rst_n = 1'b1;
    step();
    check("midrst_restart", sum, 20'd9);

    do_reset("rst_par");
    @(negedge clk);
    for (int i = 0; i < 25; i++) w_tmp[16*i +: 16] = 16'(i + 1);
    p = '1;
    w = w_tmp;
    step();
    check("parallel", sum, 20'd325);
    @(negedge clk);
    p = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("par_hold", sum, 20'd325);
    end

    do_reset("rst_gate");
    @(negedge clk);
    for (int i = 0; i < 25; i++) w_tmp[16*i +: 16] = 16'h0010;
    w_tmp[15:0]    = 16'h0003;
    w_tmp[399:384] = 16'h0007;
    w = w_tmp;
    p = 25'h0000001;
    step();
    check("gate_lane0", sum, 20'd3);
    @(negedge clk);
    p = 25'h1000000;
    step();
    check("gate_lane24", sum, 20'd10);

    do_reset("rst_wrap");
    @(negedge clk);
    p = '1;
    w = '1;
    step();
    check("max", sum, 20'h8FFE7);
    step();
    check("wrap", sum, 20'h1FFCE);
    @(negedge clk);
    p = '0;
    step();
    check("wrap_hold", sum, 20'h1FFCE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
